// File: rtl/bilinear_pkg.sv
// Shared constants, FSM state encoding and the per-axis coordinate helper
// for the bilinear resampler.
package bilinear_pkg;

   localparam int Q_FRAC = 8;
   localparam int ONE_Q  = 256;
   localparam int ADDR_W = 32;
   localparam int PIX_W  = 8;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_CALC = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   typedef struct packed {
      logic [15:0]       c0;
      logic [15:0]       c1;
      logic [Q_FRAC-1:0] f;
   } axis_t;

   // Splits a Q24.8 source coordinate into clamped neighbour indices and a
   // fraction; the fraction is dropped when the coordinate runs off the edge.
   function automatic axis_t resolve_axis(input logic [31:0] s, input logic [15:0] size);
      logic [23:0] whole;
      logic [15:0] lim;
      axis_t       r;
      whole = 24'(s >> Q_FRAC);
      lim   = size - 16'd1;
      if (whole > {8'd0, lim}) begin
         r.c0 = lim;
         r.f  = '0;
      end else begin
         r.c0 = whole[15:0];
         r.f  = s[Q_FRAC-1:0];
      end
      r.c1 = (r.c0 < lim) ? r.c0 + 16'd1 : lim;
      return r;
   endfunction

endpackage

// File: rtl/bilinear_lane.sv
// One SIMD lane: neighbour address generation and the Q8.8 interpolation.
// Build option BILINEAR_ROUND_EN selects round-half-up instead of truncation.
module bilinear_lane
   import bilinear_pkg::*;
#(
   parameter int K = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_addr,
   input  logic              load_data,
   input  logic [15:0]       x,
   input  logic [15:0]       y,
   input  logic [15:0]       in_w,
   input  logic [15:0]       in_h,
   input  logic [15:0]       out_w,
   input  logic [15:0]       inv_scale_q,
   input  logic [PIX_W-1:0]  rd_data0,
   input  logic [PIX_W-1:0]  rd_data1,
   input  logic [PIX_W-1:0]  rd_data2,
   input  logic [PIX_W-1:0]  rd_data3,
   output logic              active,
   output logic [ADDR_W-1:0] rd_addr0,
   output logic [ADDR_W-1:0] rd_addr1,
   output logic [ADDR_W-1:0] rd_addr2,
   output logic [ADDR_W-1:0] rd_addr3,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [PIX_W-1:0]  wr_data
);

   logic [31:0]       px, sx, sy, row0, row1;
   axis_t             xa, ya;
   logic [Q_FRAC-1:0] fx_reg, fy_reg;
   logic [8:0]        wfx, wfy;
   logic [16:0]       top, bot;
   logic [24:0]       acc;
   logic [25:0]       acc_r, q;

   assign px     = {16'd0, x} + 32'(K);
   assign sx     = px * {16'd0, inv_scale_q};
   assign sy     = {16'd0, y} * {16'd0, inv_scale_q};
   assign xa     = resolve_axis(sx, in_w);
   assign ya     = resolve_axis(sy, in_h);
   assign row0   = {16'd0, ya.c0} * {16'd0, in_w};
   assign row1   = {16'd0, ya.c1} * {16'd0, in_w};
   assign active = px < {16'd0, out_w};

   assign wfx = 9'(ONE_Q) - {1'b0, fx_reg};
   assign wfy = 9'(ONE_Q) - {1'b0, fy_reg};
   assign top = {9'd0, rd_data0} * {8'd0, wfx} + {9'd0, rd_data1} * {9'd0, fx_reg};
   assign bot = {9'd0, rd_data2} * {8'd0, wfx} + {9'd0, rd_data3} * {9'd0, fx_reg};
   assign acc = {8'd0, top} * {16'd0, wfy} + {8'd0, bot} * {17'd0, fy_reg};

`ifdef BILINEAR_ROUND_EN
   assign acc_r = {1'b0, acc} + 26'd32768;
`else
   assign acc_r = {1'b0, acc};
`endif
   assign q = acc_r >> (2 * Q_FRAC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr0 <= '0;
         rd_addr1 <= '0;
         rd_addr2 <= '0;
         rd_addr3 <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
         fx_reg   <= '0;
         fy_reg   <= '0;
      end else begin
         if (load_addr) begin
            rd_addr0 <= row0 + {16'd0, xa.c0};
            rd_addr1 <= row0 + {16'd0, xa.c1};
            rd_addr2 <= row1 + {16'd0, xa.c0};
            rd_addr3 <= row1 + {16'd0, xa.c1};
            wr_addr  <= {16'd0, y} * {16'd0, out_w} + px;
            fx_reg   <= xa.f;
            fy_reg   <= ya.f;
         end
         if (load_data) begin
            wr_data <= (q > 26'd255) ? 8'd255 : q[7:0];
         end
      end
   end

endmodule

// File: rtl/bilinear_core_simd.sv
// N-lane bilinear resampler top: job FSM, raster counters and single-step
// handshake. Rounding mode is selected by BILINEAR_ROUND_EN in bilinear_lane.
module bilinear_core_simd
   import bilinear_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [15:0]         in_w,
   input  logic [15:0]         in_h,
   input  logic [15:0]         out_w,
   input  logic [15:0]         out_h,
   input  logic [15:0]         inv_scale_q,
   input  logic                step_mode,
   input  logic                step,
   output logic                step_ack,
   output logic                busy,
   output logic                done,
   output logic [N*ADDR_W-1:0] rd_addr0,
   output logic [N*ADDR_W-1:0] rd_addr1,
   output logic [N*ADDR_W-1:0] rd_addr2,
   output logic [N*ADDR_W-1:0] rd_addr3,
   input  logic [N*PIX_W-1:0]  rd_data0,
   input  logic [N*PIX_W-1:0]  rd_data1,
   input  logic [N*PIX_W-1:0]  rd_data2,
   input  logic [N*PIX_W-1:0]  rd_data3,
   output logic [N-1:0]        wr_valid,
   output logic [N*ADDR_W-1:0] wr_addr,
   output logic [N*PIX_W-1:0]  wr_data
);

   state_t      state;
   logic [15:0] x, y;
   logic [15:0] cfg_in_w, cfg_in_h, cfg_out_w, cfg_out_h, cfg_inv;
   logic        fire, advance;
   logic [N-1:0] lane_active;

   // In step mode every transition consumes exactly one rising step handshake.
   assign fire     = step_mode ? (step && !step_ack) : 1'b1;
   assign advance  = fire && ((state != S_IDLE) || start);
   assign wr_valid = (state == S_WR && advance) ? lane_active : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         x         <= '0;
         y         <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         step_ack  <= 1'b0;
         cfg_in_w  <= '0;
         cfg_in_h  <= '0;
         cfg_out_w <= '0;
         cfg_out_h <= '0;
         cfg_inv   <= '0;
      end else begin
         if (!step_mode)   step_ack <= 1'b0;
         else if (advance) step_ack <= 1'b1;
         else if (!step)   step_ack <= 1'b0;

         if (advance) begin
            case (state)
               S_IDLE: begin
                  cfg_in_w  <= in_w;
                  cfg_in_h  <= in_h;
                  cfg_out_w <= out_w;
                  cfg_out_h <= out_h;
                  cfg_inv   <= inv_scale_q;
                  done      <= 1'b0;
                  busy      <= 1'b1;
                  x         <= '0;
                  y         <= '0;
                  state     <= (out_w == 16'd0 || out_h == 16'd0) ? S_DONE : S_ADDR;
               end
               S_ADDR: state <= S_CALC;
               S_CALC: state <= S_WR;
               S_WR: begin
                  if (17'(x) + 17'(N) >= {1'b0, cfg_out_w}) begin
                     x     <= '0;
                     y     <= y + 16'd1;
                     state <= ({1'b0, y} + 17'd1 >= {1'b0, cfg_out_h}) ? S_DONE : S_ADDR;
                  end else begin
                     x     <= x + 16'(N);
                     state <= S_ADDR;
                  end
               end
               S_DONE: begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         bilinear_lane #(.K(gi)) u_lane (
            .clk         (clk),
            .rst         (rst),
            .load_addr   (state == S_ADDR && advance),
            .load_data   (state == S_CALC && advance),
            .x           (x),
            .y           (y),
            .in_w        (cfg_in_w),
            .in_h        (cfg_in_h),
            .out_w       (cfg_out_w),
            .inv_scale_q (cfg_inv),
            .rd_data0    (rd_data0[gi*PIX_W +: PIX_W]),
            .rd_data1    (rd_data1[gi*PIX_W +: PIX_W]),
            .rd_data2    (rd_data2[gi*PIX_W +: PIX_W]),
            .rd_data3    (rd_data3[gi*PIX_W +: PIX_W]),
            .active      (lane_active[gi]),
            .rd_addr0    (rd_addr0[gi*ADDR_W +: ADDR_W]),
            .rd_addr1    (rd_addr1[gi*ADDR_W +: ADDR_W]),
            .rd_addr2    (rd_addr2[gi*ADDR_W +: ADDR_W]),
            .rd_addr3    (rd_addr3[gi*ADDR_W +: ADDR_W]),
            .wr_addr     (wr_addr[gi*ADDR_W +: ADDR_W]),
            .wr_data     (wr_data[gi*PIX_W +: PIX_W])
         );
      end
   endgenerate

endmodule

// File: tb/tb_bilinear_core_simd.sv
// Directed bench for bilinear_core_simd: ramp downscale, edge clamp, partial
// group, single-step mode, async reset abort and empty job.
module tb_bilinear_core_simd;

   localparam int NL = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [15:0]     in_w = '0, in_h = '0, out_w = '0, out_h = '0, inv_scale_q = '0;
   logic            step_mode = 1'b0, step = 1'b0;
   logic            step_ack, busy, done;
   logic [NL*32-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
   logic [NL*8-1:0]  rd_data0, rd_data1, rd_data2, rd_data3;
   logic [NL-1:0]    wr_valid;
   logic [NL*32-1:0] wr_addr;
   logic [NL*8-1:0]  wr_data;

   logic [7:0]  in_mem  [0:1023];
   logic [7:0]  out_mem [0:1023];
   logic        clr = 1'b0;
   int          wr_cnt;
   logic        bad_wr;
   logic [NL-1:0] last_wv;
   int          lim_total = 0;
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   bilinear_core_simd #(.N(NL)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_w(in_w), .in_h(in_h), .out_w(out_w), .out_h(out_h),
      .inv_scale_q(inv_scale_q), .step_mode(step_mode), .step(step),
      .step_ack(step_ack), .busy(busy), .done(done),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
      .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   function automatic logic [7:0] rd(input logic [31:0] a);
      return (a < 32'd1024) ? in_mem[a[9:0]] : 8'h00;
   endfunction

   always_comb begin
      rd_data0 = '0;
      rd_data1 = '0;
      rd_data2 = '0;
      rd_data3 = '0;
      for (int k = 0; k < NL; k++) begin
         rd_data0[k*8 +: 8] = rd(rd_addr0[k*32 +: 32]);
         rd_data1[k*8 +: 8] = rd(rd_addr1[k*32 +: 32]);
         rd_data2[k*8 +: 8] = rd(rd_addr2[k*32 +: 32]);
         rd_data3[k*8 +: 8] = rd(rd_addr3[k*32 +: 32]);
      end
   end

   // Output frame model: records every strobed lane write.
   always @(posedge clk) begin
      if (clr) begin
         wr_cnt  <= 0;
         bad_wr  <= 1'b0;
         last_wv <= '0;
         for (int i = 0; i < 1024; i++) out_mem[i] <= 8'hEE;
      end else begin
         for (int k = 0; k < NL; k++) begin
            if (wr_valid[k]) begin
               if (wr_addr[k*32 +: 32] < 32'd1024) out_mem[wr_addr[k*32 +: 10]] <= wr_data[k*8 +: 8];
               if (wr_addr[k*32 +: 32] >= 32'(lim_total)) bad_wr <= 1'b1;
            end
         end
         wr_cnt <= wr_cnt + $countones(wr_valid);
         if (|wr_valid) last_wv <= wr_valid;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_out();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic load_ramp();
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++)
            in_mem[r*32 + c] = 8'((8 * c) % 256);
   endtask

   task automatic set_job(input logic [15:0] iw, ih, ow, oh, inv);
      in_w = iw; in_h = ih; out_w = ow; out_h = oh; inv_scale_q = inv;
      lim_total = int'(ow) * int'(oh);
   endtask

   task automatic run_job(input logic [15:0] iw, ih, ow, oh, inv, output int cyc);
      @(negedge clk);
      set_job(iw, ih, ow, oh, inv);
      step_mode = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 1;
      while (!done && cyc < 5000) begin
         @(posedge clk);
         #1 cyc++;
      end
      $display("job %0dx%0d -> %0dx%0d inv=%0d: %0d cycles, %0d writes", iw, ih, ow, oh, inv, cyc, wr_cnt);
   endtask

   task automatic check_ramp(input string tag);
      for (int i = 0; i < 256; i++)
         check($sformatf("%s[%0d]", tag, i), 32'(out_mem[i]), 32'((16 * (i % 16)) % 256));
   endtask

   int cyc, n, t, timeouts;
   logic [7:0] exp2 [0:3];

   initial begin
      for (int i = 0; i < 1024; i++) in_mem[i] = 8'h00;
      #3;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_step_ack", 32'(step_ack), 0);
      check("rst_wr_valid", 32'(wr_valid), 0);
      check("rst_rd_addr3", rd_addr3[31:0], 0);
      check("rst_wr_addr", wr_addr[31:0], 0);
      check("rst_wr_data", 32'(wr_data), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 32x32 ramp halved to 16x16
      load_ramp();
      clear_out();
      run_job(16'd32, 16'd32, 16'd16, 16'd16, 16'd512, cyc);
      check("ramp_cycles", 32'(cyc), 194);
      check("ramp_done", 32'(done), 1);
      check("ramp_busy", 32'(busy), 0);
      check("ramp_writes", 32'(wr_cnt), 256);
      check_ramp("ramp");

      // 2x2 upscale to 4x1 with right-edge clamp
      in_mem[0] = 8'd0; in_mem[1] = 8'd100; in_mem[2] = 8'd200; in_mem[3] = 8'd50;
      exp2[0] = 8'd0; exp2[1] = 8'd50; exp2[2] = 8'd100; exp2[3] = 8'd100;
      clear_out();
      run_job(16'd2, 16'd2, 16'd4, 16'd1, 16'd128, cyc);
      check("up_writes", 32'(wr_cnt), 4);
      for (int i = 0; i < 4; i++) check($sformatf("up[%0d]", i), 32'(out_mem[i]), 32'(exp2[i]));

      // partial second group: only lane 0 active
      load_ramp();
      clear_out();
      run_job(16'd32, 16'd32, 16'd5, 16'd1, 16'd256, cyc);
      check("part_cycles", 32'(cyc), 8);
      check("part_writes", 32'(wr_cnt), 5);
      check("part_last_wv", 32'(last_wv), 32'b0001);
      check("part_bad_addr", 32'(bad_wr), 0);
      for (int i = 0; i < 5; i++) check($sformatf("part[%0d]", i), 32'(out_mem[i]), 32'(8 * i));
      check("part_untouched5", 32'(out_mem[5]), 32'hEE);

      // single-step mode, same job as the ramp
      clear_out();
      @(negedge clk);
      set_job(16'd32, 16'd32, 16'd16, 16'd16, 16'd512);
      step_mode = 1'b1;
      start = 1'b1;
      n = 0;
      timeouts = 0;
      do begin
         step = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end while (!step_ack && t < 20);
         if (!step_ack) timeouts++;
         start = 1'b0;
         n++;
         step = 1'b0;
         t = 0;
         do begin @(negedge clk); t++; end while (step_ack && t < 20);
         if (step_ack) timeouts++;
      end while (!done && n < 400);
      $display("step job: %0d handshakes, %0d writes", n, wr_cnt);
      check("step_timeouts", 32'(timeouts), 0);
      check("step_handshakes", 32'(n), 194);
      check("step_done", 32'(done), 1);
      check("step_writes", 32'(wr_cnt), 256);
      check_ramp("step");
      @(negedge clk);
      step_mode = 1'b0;

      // asynchronous reset mid-row
      clear_out();
      @(negedge clk);
      set_job(16'd32, 16'd32, 16'd16, 16'd16, 16'd512);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (20) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      $display("reset pulsed mid-job after %0d writes", wr_cnt);
      check("abort_busy", 32'(busy), 0);
      check("abort_wr_valid", 32'(wr_valid), 0);
      check("abort_rd_addr0", rd_addr0[31:0], 0);
      check("abort_wr_addr", wr_addr[31:0], 0);
      check("abort_wr_data", 32'(wr_data), 0);
      @(negedge clk);
      rst = 1'b0;
      in_mem[0] = 8'd0; in_mem[1] = 8'd100; in_mem[2] = 8'd200; in_mem[3] = 8'd50;
      clear_out();
      run_job(16'd2, 16'd2, 16'd4, 16'd1, 16'd128, cyc);
      check("post_rst_writes", 32'(wr_cnt), 4);
      for (int i = 0; i < 4; i++) check($sformatf("post_rst[%0d]", i), 32'(out_mem[i]), 32'(exp2[i]));

      // empty job
      clear_out();
      run_job(16'd2, 16'd2, 16'd0, 16'd3, 16'd128, cyc);
      check("empty_cycles", 32'(cyc), 2);
      check("empty_done", 32'(done), 1);
      check("empty_writes", 32'(wr_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
